// File: rtl/ula_serial_pkg.sv
// Shared constants for the bit-serial 4-bit ALU: opcodes, logic functions,
// FSM state encoding and datapath widths.
package ula_pkg;

   localparam int ULA_W = 4;
   localparam int CNT_W = 2;

   localparam logic [1:0] MNM_MOV = 2'b00;
   localparam logic [1:0] MNM_LOG = 2'b01;
   localparam logic [1:0] MNM_ADD = 2'b10;
   localparam logic [1:0] MNM_SUB = 2'b11;

   localparam logic [1:0] FN_AND = 2'b00;
   localparam logic [1:0] FN_OR  = 2'b01;
   localparam logic [1:0] FN_XOR = 2'b10;
   localparam logic [1:0] FN_NOT = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/ula_serial_if.sv
// Controller <-> ALU bundle: ena_ula/ula_ack handshake, opcode, operands,
// and registered result/flags. master = controller, slave = ALU.
interface ula_serial_if;
   import ula_pkg::*;

   logic             ena_ula;
   logic [1:0]       mnm_in;
   logic [1:0]       func_in;
   logic [ULA_W-1:0] a_in;
   logic [ULA_W-1:0] b_in;
   logic             ula_ack;
   logic [ULA_W-1:0] result_out;
   logic             carry_out;
   logic             zero_out;

   modport master (
      output ena_ula, mnm_in, func_in, a_in, b_in,
      input  ula_ack, result_out, carry_out, zero_out
   );

   modport slave (
      input  ena_ula, mnm_in, func_in, a_in, b_in,
      output ula_ack, result_out, carry_out, zero_out
   );

endinterface

// File: rtl/ula_serial_bit_slice.sv
// Combinational one-bit ALU slice.
// Ports: a, b, cin, mnm, fn in; r (result bit), cout (carry out) out.
module ula_bit_slice
   import ula_pkg::*;
(
   input  logic       a,
   input  logic       b,
   input  logic       cin,
   input  logic [1:0] mnm,
   input  logic [1:0] fn,
   output logic       r,
   output logic       cout
);

   logic bx;

   // Subtraction is A + ~B + 1; the +1 comes from the preset carry.
   assign bx = b ^ (mnm == MNM_SUB);

   always_comb begin
      r    = 1'b0;
      cout = 1'b0;
      case (mnm)
         MNM_MOV: r = b;
         MNM_LOG: begin
            case (fn)
               FN_AND:  r = a & b;
               FN_OR:   r = a | b;
               FN_XOR:  r = a ^ b;
               default: r = ~a;
            endcase
         end
         default: begin
            r    = a ^ bx ^ cin;
            cout = (a & bx) | (a & cin) | (bx & cin);
         end
      endcase
   end

endmodule

// File: rtl/ula_serial.sv
// Bit-serial 4-bit ALU, responder side of the ena_ula/ula_ack handshake.
// Ports: clk, rst (sync, active-high), bus (ula_serial_if.slave).
// Build option: define ULA_FLAGS_EN to include carry/zero flag registers;
// otherwise carry_out and zero_out are tied to 0.
module ula_serial
   import ula_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   ula_serial_if.slave  bus
);

   state_t state;
   state_t state_nxt;

   logic [ULA_W-1:0] a_sr;
   logic [ULA_W-1:0] b_sr;
   logic [ULA_W-1:0] res_sr;
   logic [ULA_W-1:0] res_nxt;
   logic [ULA_W-1:0] result_r;
   logic [1:0]       mnm_r;
   logic [1:0]       fn_r;
   logic [CNT_W-1:0] cnt;
   logic             cy;
   logic             bit_r;
   logic             bit_c;
   logic             last;
   logic             ld;
   logic             step;
   logic             fin;
   logic             ack;

   assign last = (cnt == CNT_W'(ULA_W - 1));

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:
            if (bus.ena_ula) state_nxt = S_EXEC;
         S_EXEC:
            if (!bus.ena_ula) state_nxt = S_IDLE;
            else if (last)    state_nxt = S_DONE;
         S_DONE:
            if (!bus.ena_ula) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      ld   = (state == S_IDLE) && bus.ena_ula;
      step = (state == S_EXEC) && bus.ena_ula;
      fin  = step && last;
      ack  = (state == S_DONE);
   end

   ula_bit_slice u_slice (
      .a    (a_sr[0]),
      .b    (b_sr[0]),
      .cin  (cy),
      .mnm  (mnm_r),
      .fn   (fn_r),
      .r    (bit_r),
      .cout (bit_c)
   );

   // LSB-first: each new bit enters at the top and drifts down.
   assign res_nxt = {bit_r, res_sr[ULA_W-1:1]};

   always_ff @(posedge clk) begin
      if (rst) begin
         a_sr     <= '0;
         b_sr     <= '0;
         res_sr   <= '0;
         result_r <= '0;
         mnm_r    <= '0;
         fn_r     <= '0;
         cnt      <= '0;
         cy       <= 1'b0;
      end else if (ld) begin
         a_sr   <= bus.a_in;
         b_sr   <= bus.b_in;
         res_sr <= '0;
         mnm_r  <= bus.mnm_in;
         fn_r   <= bus.func_in;
         cnt    <= '0;
         cy     <= (bus.mnm_in == MNM_SUB);
      end else if (step) begin
         a_sr   <= a_sr >> 1;
         b_sr   <= b_sr >> 1;
         res_sr <= res_nxt;
         cy     <= bit_c;
         cnt    <= cnt + 1'b1;
         if (fin) result_r <= res_nxt;
      end
   end

   assign bus.ula_ack    = ack;
   assign bus.result_out = result_r;

`ifdef ULA_FLAGS_EN
   logic carry_r;
   logic zero_r;

   // Slice carry-out is 0 for logic/move, so no opcode gating is needed.
   always_ff @(posedge clk) begin
      if (rst) begin
         carry_r <= 1'b0;
         zero_r  <= 1'b0;
      end else if (fin) begin
         carry_r <= bit_c;
         zero_r  <= (res_nxt == '0);
      end
   end

   assign bus.carry_out = carry_r;
   assign bus.zero_out  = zero_r;
`else
   assign bus.carry_out = 1'b0;
   assign bus.zero_out  = 1'b0;
`endif

endmodule

// File: tb/tb_ula_serial.sv
// Scoreboard bench for ula_serial: stimulus pushes expected results,
// a negedge monitor pops and compares on each rising ula_ack.
module tb_ula_serial;
   import ula_pkg::*;

   logic clk = 1'b0;
   logic rst;

   ula_serial_if bus ();

   ula_serial dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   logic [5:0] exp_q[$];
   logic [5:0] last_out = 6'h0;
   logic       ack_q    = 1'b0;
   logic [5:0] got;
   logic [5:0] want;

   function automatic logic [5:0] model(input int mnm, input int fn,
                                        input int a, input int b);
      int r;
      int c;
      r = 0;
      c = 0;
      case (mnm)
         0: r = b;
         1: case (fn)
               0:       r = a & b;
               1:       r = a | b;
               2:       r = a ^ b;
               default: r = (~a) & 15;
            endcase
         2: begin
            r = (a + b) % 16;
            c = (a + b > 15) ? 1 : 0;
         end
         default: begin
            r = (a - b + 16) % 16;
            c = (a >= b) ? 1 : 0;
         end
      endcase
`ifdef ULA_FLAGS_EN
      return {r[3:0], c[0], (r == 0)};
`else
      return {r[3:0], 2'b00};
`endif
   endfunction

   function automatic logic [5:0] outs();
      return {bus.result_out, bus.carry_out, bus.zero_out};
   endfunction

   always @(negedge clk) begin
      if (bus.ula_ack && !ack_q) begin
         got = outs();
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_ack got=%h required=no_ack", got);
         end else begin
            want = exp_q.pop_front();
            if (got !== want) begin
               failures++;
               $display("FAIL result got=%h required=%h", got, want);
            end
         end
      end
      ack_q = bus.ula_ack;
   end

   task automatic drive(input int mnm, input int fn,
                        input int a, input int b);
      bus.mnm_in  = 2'(mnm);
      bus.func_in = 2'(fn);
      bus.a_in    = 4'(a);
      bus.b_in    = 4'(b);
   endtask

   task automatic scramble();
      drive($urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 15), $urandom_range(0, 15));
   endtask

   task automatic do_op(input int mnm, input int fn, input int a,
                        input int b, input bit scr);
      int n;
      int h;
      @(negedge clk);
      drive(mnm, fn, a, b);
      bus.ena_ula = 1'b1;
      exp_q.push_back(model(mnm, fn, a, b));
      last_out = model(mnm, fn, a, b);
      n = 0;
      do begin
         @(negedge clk);
         n++;
         if (scr) scramble();
      end while (!bus.ula_ack && n < 20);
      checks++;
      if (n != 5) begin
         failures++;
         $display("FAIL latency got=%0d required=5", n);
      end
      h = $urandom_range(0, 2);
      repeat (h) begin
         @(negedge clk);
         checks++;
         if (bus.ula_ack !== 1'b1) begin
            failures++;
            $display("FAIL ack_hold got=%b required=1", bus.ula_ack);
         end
      end
      bus.ena_ula = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.ula_ack !== 1'b0) begin
         failures++;
         $display("FAIL ack_drop got=%b required=0", bus.ula_ack);
      end
   endtask

   task automatic abort_op(input int k, input int a, input int b);
      @(negedge clk);
      drive(2, 0, a, b);
      bus.ena_ula = 1'b1;
      repeat (k + 1) @(negedge clk);
      bus.ena_ula = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (bus.ula_ack !== 1'b0 || outs() !== last_out) begin
         failures++;
         $display("FAIL abort got=%b/%h required=0/%h",
                  bus.ula_ack, outs(), last_out);
      end
   endtask

   initial begin
      rst         = 1'b1;
      bus.ena_ula = 1'b1;
      drive(2, 0, 9, 8);
      repeat (2) @(negedge clk);
      checks++;
      if (bus.ula_ack !== 1'b0 || outs() !== 6'h0) begin
         failures++;
         $display("FAIL reset_state got=%b/%h required=0/00",
                  bus.ula_ack, outs());
      end
      rst         = 1'b0;
      bus.ena_ula = 1'b0;
      repeat (6) @(negedge clk);
      checks++;
      if (bus.ula_ack !== 1'b0) begin
         failures++;
         $display("FAIL rst_req_captured got=%b required=0", bus.ula_ack);
      end

      do_op(2, 0, 9, 8, 1'b0);
      do_op(3, 0, 5, 5, 1'b0);
      do_op(3, 0, 3, 5, 1'b0);
      do_op(1, 2, 10, 15, 1'b0);
      do_op(1, 3, 3, 0, 1'b0);
      do_op(0, 0, 0, 7, 1'b0);
      abort_op(2, 1, 1);
      do_op(2, 0, 2, 3, 1'b0);
      do_op(2, 0, 6, 7, 1'b1);
      do_op(3, 0, 12, 4, 1'b1);

      @(negedge clk);
      drive(2, 0, 15, 15);
      bus.ena_ula = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.ula_ack !== 1'b0 || outs() !== 6'h0) begin
         failures++;
         $display("FAIL mid_reset got=%b/%h required=0/00",
                  bus.ula_ack, outs());
      end
      rst         = 1'b0;
      bus.ena_ula = 1'b0;
      last_out    = 6'h0;
      @(negedge clk);

      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 7) == 0)
            abort_op($urandom_range(0, 3), $urandom_range(0, 15),
                     $urandom_range(0, 15));
         else
            do_op($urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 15), $urandom_range(0, 15),
                  ($urandom_range(0, 4) == 0));
      end

      repeat (3) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL pending got=%0d required=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ula_serial.md
# ula_serial

Bit-serial 4-bit arithmetic/logic unit and the responder side of the controller's `ena_ula`/`ula_ack` handshake. The controller raises `ena_ula` in its Arit/Logica states and holds it until `ula_ack`. This block then captures the operands, processes one bit per cycle LSB-first, registers the result and flags, and raises `ula_ack`. The result feeds the register-bank write-back path (WB_Rd/WB_R0).

## Interface
Parameters: none. Width is fixed at 4 bits.

Clocking: one clock; reset is synchronous and active-high.

- `clk` input 1: clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `ena_ula` input 1: request from controller; level, held until ack.
- `mnm_in` input 2: instruction mnemonic.
  - 00 move B
  - 01 logic
  - 10 add
  - 11 subtract
- `func_in` input 2: logic function, used when `mnm_in`=01.
  - 00 AND
  - 01 OR
  - 10 XOR
  - 11 NOT A
- `a_in` input 4: operand A (R0/Rd data).
- `b_in` input 4: operand B (data/immediate).
- `ula_ack` output 1: completion acknowledge.
- `result_out` output 4: registered result.
- `carry_out` output 1: registered carry flag (see Configuration).
- `zero_out` output 1: registered zero flag (see Configuration).

## Operation
- FSM states: IDLE, EXEC, DONE.
- IDLE:
  - If `ena_ula`=1 at edge E0: capture `a_in`, `b_in`, `mnm_in`, `func_in` into internal shift/opcode registers; clear bit counter; set serial carry (1 for SUB, else 0); go to EXEC.
  - Otherwise stay in IDLE.
- EXEC, edges E1..E4, bit i = 0..3:
  - Compute one result bit from A[i], B[i] and the serial carry, then shift it into the result shift register.
  - ADD: bit-serial full add.
  - SUB: A + ~B + 1 (carry preset to 1).
  - Logic ops: bitwise.
  - Move: result bit = B[i].
  - At E4: load `result_out` from the completed shift register, update flags, set `ula_ack`=1, go to DONE.
- DONE:
  - `ula_ack` held 1 while `ena_ula`=1.
  - The first edge sampling `ena_ula`=0 clears `ula_ack` and returns to IDLE.
  - Four-phase handshake. A new request is accepted only from IDLE.
- Abort: `ena_ula` sampled 0 in EXEC → return to IDLE. No ack. `result_out` and flags unchanged.
- Operand/opcode inputs are ignored after E0. Changes during EXEC/DONE have no effect.
- Flag rules:
  - carry = final serial carry-out for ADD/SUB (SUB: 1 = no borrow, A ≥ B); 0 for logic/move.
  - zero = (4-bit result == 0).
  - Results wrap modulo 16.
- Reset (any state, including mid-EXEC): next edge gives state IDLE, `ula_ack`=0, `result_out`=0, `carry_out`=0, `zero_out`=0, counter and shift registers 0.

## Timing
- Latency: `ula_ack` is visible after edge E4. That is the 5th rising edge sampling `ena_ula`=1, counting E0.
- Minimum request-to-request spacing: one IDLE cycle after ack drops.
- `result_out` and flags are valid from the same cycle `ula_ack` rises. They stay stable until the next completed operation or reset.
- Simultaneous `rst` and `ena_ula`: reset wins and the request is not captured.

## Configuration
- `ULA_FLAGS_EN` defined: carry/zero flag registers and logic are compiled in, per the flag rules above.
- `ULA_FLAGS_EN` undefined: flag registers are removed. `carry_out` and `zero_out` are tied to 0. Result and handshake behaviour are identical.

## Structure
- Package `ula_pkg` holds:
  - mnemonic localparams: MNM_MOV, MNM_LOG, MNM_ADD, MNM_SUB
  - function codes: FN_AND, FN_OR, FN_XOR, FN_NOT
  - state encoding: S_IDLE, S_EXEC, S_DONE
  - constant ULA_W=4
- One sub-module, `ula_bit_slice`, is combinational. It takes one bit of A/B, the carry-in, mnemonic and function. It returns the result bit and carry-out.
- The top level holds the FSM, counter, shift registers, output registers and the flag logic.

## Test plan
- ADD, `a`=9, `b`=8, hold `ena_ula` → `ula_ack` after E4; `result_out`=1, `carry_out`=1, `zero_out`=0. Ack stays high until `ena_ula` drops, then low one edge later.
- SUB, `a`=5, `b`=5 → `result_out`=0, `carry_out`=1, `zero_out`=1. Then SUB `a`=3, `b`=5 → `result_out`=E, `carry_out`=0.
- Logic: XOR `a`=A, `b`=F → 5. NOT `a`=3 → C. Move `b`=7 → 7. Carry=0 on all.
- Abort: drop `ena_ula` after E2 of ADD 1+1 → no ack, `result_out` keeps its previous value. Next request completes normally with 5-cycle latency.
- Change `a_in`/`b_in` every cycle during EXEC → result reflects E0 operands only.
- Assert `rst` mid-EXEC → next edge: all outputs 0, IDLE. Build without `ULA_FLAGS_EN` → flags stay 0 across all tests above.
